// File: rtl/tv80_regbank_pkg.sv
// tv80_regbank_pkg: shared pair indices, dump FSM states and physical-size helper
package tv80_regbank_pkg;
  localparam int BC = 0;
  localparam int DE = 1;
  localparam int HL = 2;
  typedef enum logic {IDLE, RUN} dump_state_t;
  function automatic int nphys(input int nbanks, input int nregs);
    return 3 * nbanks + nregs - 3;
  endfunction
endpackage

// File: rtl/tv80_regbank_map.sv
// tv80_regbank_map: logical pair address to physical pair index through bank and DE/HL swap
module tv80_regbank_map
  import tv80_regbank_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int NBANKS = 2,
  localparam int AW = $clog2(NREGS),
  localparam int BW = NBANKS > 1 ? $clog2(NBANKS) : 1,
  localparam int IW = $clog2(nphys(NBANKS, NREGS))
) (
  input  logic [AW-1:0]     addr,
  input  logic [BW-1:0]     bank,
  input  logic [NBANKS-1:0] swap,
  output logic [IW-1:0]     phys
);
  logic          sw;
  logic [IW-1:0] base;
  assign sw   = swap[bank];
  assign base = IW'(3 * int'(bank));
  assign phys = addr == AW'(BC) ? base :
                addr == AW'(DE) ? base + (sw ? IW'(HL) : IW'(DE)) :
                addr == AW'(HL) ? base + (sw ? IW'(DE) : IW'(HL)) :
                IW'(3 * NBANKS + int'(addr) - 3);
endmodule

// File: rtl/tv80_regbank.sv
// tv80_regbank: banked TV80 register file with EXX / EX DE,HL remapping and a debug dump port; TV80_REGBANK_BYPASS_EN enables write-to-read forwarding
module tv80_regbank
  import tv80_regbank_pkg::*;
#(
  parameter int DW = 8,
  parameter int NREGS = 8,
  parameter int NBANKS = 2,
  localparam int AW = $clog2(NREGS),
  localparam int BW = NBANKS > 1 ? $clog2(NBANKS) : 1,
  localparam int NPHYS = nphys(NBANKS, NREGS),
  localparam int IW = $clog2(NPHYS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cen,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [AW-1:0] addr_c,
  input  logic [DW-1:0] dih,
  input  logic [DW-1:0] dil,
  input  logic          weh,
  input  logic          wel,
  output logic [DW-1:0] doah,
  output logic [DW-1:0] doal,
  output logic [DW-1:0] dobh,
  output logic [DW-1:0] dobl,
  output logic [DW-1:0] doch,
  output logic [DW-1:0] docl,
  input  logic          exx,
  input  logic          ex_dehl,
  output logic [2*DW-1:0] bc,
  output logic [2*DW-1:0] de,
  output logic [2*DW-1:0] hl,
  output logic [BW-1:0] bank,
  input  logic          dump_req,
  input  logic          dump_ready,
  output logic          dump_valid,
  output logic [IW-1:0] dump_idx,
  output logic [2*DW-1:0] dump_data,
  output logic          dump_busy
);
  logic [DW-1:0]     rh [NPHYS];
  logic [DW-1:0]     rl [NPHYS];
  logic [NBANKS-1:0] swap;
  logic [AW-1:0]     la [6];
  logic [IW-1:0]     p [7];
  logic [DW-1:0]     hv [7];
  logic [DW-1:0]     lv [7];
  dump_state_t       st, st_n;
  logic [IW-1:0]     idx, idx_n;
  assign la[0] = addr_a;
  assign la[1] = addr_b;
  assign la[2] = addr_c;
  assign la[3] = AW'(BC);
  assign la[4] = AW'(DE);
  assign la[5] = AW'(HL);
  assign p[6]  = idx;
  for (genvar g = 0; g < 6; g++) begin : g_map
    tv80_regbank_map #(.NREGS(NREGS), .NBANKS(NBANKS)) u_map (
      .addr(la[g]),
      .bank(bank),
      .swap(swap),
      .phys(p[g])
    );
  end
  for (genvar g = 0; g < 7; g++) begin : g_rd
`ifdef TV80_REGBANK_BYPASS_EN
    assign hv[g] = (cen && weh && p[g] == p[0]) ? dih : rh[p[g]];
    assign lv[g] = (cen && wel && p[g] == p[0]) ? dil : rl[p[g]];
`else
    assign hv[g] = rh[p[g]];
    assign lv[g] = rl[p[g]];
`endif
  end
  assign doah = hv[0];
  assign doal = lv[0];
  assign dobh = hv[1];
  assign dobl = lv[1];
  assign doch = hv[2];
  assign docl = lv[2];
  assign bc = {hv[3], lv[3]};
  assign de = {hv[4], lv[4]};
  assign hl = {hv[5], lv[5]};
  assign dump_data  = {hv[6], lv[6]};
  assign dump_idx   = idx;
  assign dump_valid = st == RUN;
  assign dump_busy  = st == RUN;
  // register writes and exchanges, all using the mapping in force before this edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NPHYS; i++) begin
        rh[i] <= '0;
        rl[i] <= '0;
      end
      bank <= '0;
      swap <= '0;
    end else if (cen) begin
      if (weh) rh[p[0]] <= dih;
      if (wel) rl[p[0]] <= dil;
      if (exx) bank <= bank == BW'(NBANKS - 1) ? '0 : bank + BW'(1);
      if (ex_dehl) swap[bank] <= ~swap[bank];
    end
  end
  // dump FSM state and beat index
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= IDLE;
      idx <= '0;
    end else begin
      st  <= st_n;
      idx <= idx_n;
    end
  end
  // dump sequencing: start on request, advance on each accepted beat, stop after the last pair
  always_comb begin
    st_n  = st;
    idx_n = idx;
    if (st == IDLE) begin
      st_n  = dump_req ? RUN : IDLE;
      idx_n = '0;
    end else if (dump_ready) begin
      st_n  = idx == IW'(NPHYS - 1) ? IDLE : RUN;
      idx_n = idx == IW'(NPHYS - 1) ? '0 : idx + IW'(1);
    end
  end
endmodule
